mp_sram_arbiter: RTL
====================

MP_SRAM_ARBITER -- requirements
Module: mp_sram_arbiter

Interface
REQ-001 Parameter DW, default 32: data and mask width.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter NCH, default 4: number of cbus requesters, range 2..8.
REQ-004 Parameter RD_LAT, default 1: memory read latency in cycles, range 1..4.
REQ-005 Parameter MAX_WAIT, default 8: consecutive cbus-blocked cycles before the starvation guard fires, range 1..255.
REQ-006 One clock; reset is asynchronous and active-low, with ports clk and rst_n:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
REQ-007 cbus_req  input  NCH  per-channel request.
REQ-008 cbus_cmd  input  NCH  per-channel command: 1 = read, 0 = write.
REQ-009 cbus_addr  input  NCH*AW  channel i address in bits [i*AW +: AW].
REQ-010 cbus_wrdata  input  NCH*DW  channel i write data in bits [i*DW +: DW].
REQ-011 cbus_waccept  output  NCH  write accepted this cycle.
REQ-012 cbus_rresp  output  NCH  read accepted this cycle.
REQ-013 cbus_rvalid  output  NCH  read data valid for channel i.
REQ-014 cbus_rdata  output  DW  read data, shared by all channels.
REQ-015 phy_addr/phy_wr_data/phy_wr_en/phy_wr_mask/phy_en  input  AW/DW/1/DW/1  priority port.
REQ-016 phy_stall  output  1  phy request not served this cycle.
REQ-017 mem_addr/mem_wr_data/mem_wr_en/mem_wr_mask/mem_en  output  AW/DW/1/DW/1  single-port memory controls.
REQ-018 mem_rd_data  input  DW  memory read data, RD_LAT cycles after a read enable.

Function
REQ-019 The memory path SHALL be combinational: a grant and its mem_* drive occur in the same cycle as the request.
REQ-020 phy SHALL win whenever phy_en=1 and the guard is not firing; mem_* then carries phy_* unchanged, and every cbus_waccept/cbus_rresp bit is 0.
REQ-021 Otherwise, among asserted cbus_req bits, the arbiter SHALL grant the first at or after rr_ptr, searching upward modulo NCH.
REQ-022 A cbus grant SHALL drive mem_addr and mem_wr_data from the granted channel, with mem_wr_en=~cbus_cmd[g], mem_wr_mask all ones and mem_en=1.
REQ-023 A cbus grant SHALL assert exactly one of cbus_waccept[g] (write) or cbus_rresp[g] (read).
REQ-024 With no grant, mem_en SHALL be 0 and mem_wr_en SHALL be 0.
REQ-025 On each cbus grant, rr_ptr SHALL update to (g+1) mod NCH; with no cbus grant it SHALL hold.
REQ-026 A cbus read grant SHALL push {valid, g} into an RD_LAT-deep tag shift register.
REQ-027 When the tag exits the shift register, cbus_rvalid[g] SHALL be 1 for one cycle, with cbus_rdata=mem_rd_data; reads and accepts are fully pipelined.
REQ-028 phy reads SHALL push no tag; phy reads its data from mem_rd_data externally.
REQ-029 Back-to-back reads from different channels SHALL return in grant order, one per cycle.

Reset
REQ-030 While rst_n=0, the arbiter SHALL clear rr_ptr to 0, clear all tag valids, clear the wait counter, and hold cbus_rvalid=0 and phy_stall=0.
REQ-031 Reads in flight at reset SHALL be discarded, with no rvalid after reset release.
REQ-032 Combinational outputs SHALL follow REQ-019..024 during reset, except that cbus grants SHALL be suppressed while rst_n=0.

Configuration
REQ-033 Macro MP_ARB_STARVE_GUARD_EN SHALL control the starvation guard.
REQ-034 When MP_ARB_STARVE_GUARD_EN is defined:
- wait_cnt (8 bits) increments, saturating, each cycle with phy_en & |cbus_req.
- wait_cnt clears on any cbus grant or when cbus_req=0.
- When wait_cnt==MAX_WAIT, that cycle grants cbus per REQ-021, and phy_stall=1 if phy_en.
- phy SHALL hold its request while phy_stall=1.
REQ-035 When MP_ARB_STARVE_GUARD_EN is undefined, the counter SHALL be absent, phy_stall SHALL be tied 0, and phy has absolute priority.

Verification (NCH=4, RD_LAT=2, MAX_WAIT=3)
REQ-036 Scenario: cbus_req=4'b1111 writes for 4 cycles, phy idle -> waccept 0001,0010,0100,1000 and rr_ptr back to 0.
REQ-037 Scenario: read granted on ch2 at cycle 10 with mem_rd_data=32'hDEADBEEF at cycle 12 -> cbus_rresp[2]=1 at cycle 10, and cbus_rvalid=4'b0100 with rdata DEADBEEF at cycle 12.
REQ-038 Scenario: reads on ch1 then ch3 in consecutive cycles -> rvalid 0010 then 1000 on consecutive cycles, 2 cycles later.
REQ-039 Scenario: phy_en=1 with cbus_req[0]=1 for 5 cycles -> guard on: cbus_waccept[0] and phy_stall=1 in cycle 4; guard off: no cbus grant and phy_stall=0 throughout.
REQ-040 Scenario: rst_n driven low one cycle after a read grant -> no cbus_rvalid after release, and rr_ptr=0.

Source files
------------

// File: rtl/mp_sram_arbiter_if.sv
// Bus bundle for mp_sram_arbiter: cbus requesters, priority phy port and single-port memory side.
interface mp_sram_arbiter_if #(
    parameter int unsigned DW  = 32,
    parameter int unsigned AW  = 32,
    parameter int unsigned NCH = 4
) ();
    logic [NCH-1:0]    cbus_req;
    logic [NCH-1:0]    cbus_cmd;
    logic [NCH*AW-1:0] cbus_addr;
    logic [NCH*DW-1:0] cbus_wrdata;
    logic [NCH-1:0]    cbus_waccept;
    logic [NCH-1:0]    cbus_rresp;
    logic [NCH-1:0]    cbus_rvalid;
    logic [DW-1:0]     cbus_rdata;

    logic [AW-1:0]     phy_addr;
    logic [DW-1:0]     phy_wr_data;
    logic              phy_wr_en;
    logic [DW-1:0]     phy_wr_mask;
    logic              phy_en;
    logic              phy_stall;

    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wr_data;
    logic              mem_wr_en;
    logic [DW-1:0]     mem_wr_mask;
    logic              mem_en;
    logic [DW-1:0]     mem_rd_data;

    modport slave (
        input  cbus_req, cbus_cmd, cbus_addr, cbus_wrdata,
        output cbus_waccept, cbus_rresp, cbus_rvalid, cbus_rdata,
        input  phy_addr, phy_wr_data, phy_wr_en, phy_wr_mask, phy_en,
        output phy_stall,
        output mem_addr, mem_wr_data, mem_wr_en, mem_wr_mask, mem_en,
        input  mem_rd_data
    );

    modport master (
        output cbus_req, cbus_cmd, cbus_addr, cbus_wrdata,
        input  cbus_waccept, cbus_rresp, cbus_rvalid, cbus_rdata,
        output phy_addr, phy_wr_data, phy_wr_en, phy_wr_mask, phy_en,
        input  phy_stall,
        input  mem_addr, mem_wr_data, mem_wr_en, mem_wr_mask, mem_en,
        output mem_rd_data
    );
endinterface

// File: rtl/mp_sram_arbiter.sv
// Single-port SRAM arbiter: priority phy port plus round-robin cbus channels, pipelined read tags.
// Optional starvation guard enabled by defining MP_ARB_STARVE_GUARD_EN.
module mp_sram_arbiter #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 32,
    parameter int unsigned NCH      = 4,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mp_sram_arbiter_if.slave    bus
);

    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

    if (NCH < 2 || NCH > 8 || RD_LAT < 1 || RD_LAT > 4 || MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_param
        $error("mp_sram_arbiter: parameter out of range");
    end

    logic [PW-1:0]              rr_ptr_q, rr_ptr_d;
    logic [RD_LAT-1:0]          tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0][PW-1:0]  tag_ch_q, tag_ch_d;

    logic                       gnt_vld;
    logic [PW-1:0]              gnt_idx;
    logic [PW-1:0]              scan_idx;
    logic                       guard_fire;
    logic                       phy_win;
    logic                       cbus_gnt;

    // First requesting channel at or after rr_ptr, wrapping modulo NCH.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            scan_idx = PW'((32'(rr_ptr_q) + k) % NCH);
            if (!gnt_vld && bus.cbus_req[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

`ifdef MP_ARB_STARVE_GUARD_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        guard_fire = rst_n && (|bus.cbus_req) && (wait_cnt_q == 8'(MAX_WAIT));
        wait_cnt_d = wait_cnt_q;
        if (cbus_gnt || (bus.cbus_req == '0)) begin
            wait_cnt_d = '0;
        end else if (bus.phy_en && (wait_cnt_q != 8'hFF)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign bus.phy_stall = guard_fire & bus.phy_en;
`else
    assign guard_fire    = 1'b0;
    assign bus.phy_stall = 1'b0;
`endif

    // Grant selection and memory drive; cbus grants are blocked while in reset.
    always_comb begin
        phy_win          = bus.phy_en & ~guard_fire;
        cbus_gnt         = gnt_vld & rst_n & ~phy_win;
        bus.mem_addr     = '0;
        bus.mem_wr_data  = '0;
        bus.mem_wr_en    = 1'b0;
        bus.mem_wr_mask  = '0;
        bus.mem_en       = 1'b0;
        bus.cbus_waccept = '0;
        bus.cbus_rresp   = '0;
        rr_ptr_d         = rr_ptr_q;
        if (phy_win) begin
            bus.mem_addr    = bus.phy_addr;
            bus.mem_wr_data = bus.phy_wr_data;
            bus.mem_wr_en   = bus.phy_wr_en;
            bus.mem_wr_mask = bus.phy_wr_mask;
            bus.mem_en      = 1'b1;
        end else if (cbus_gnt) begin
            bus.mem_addr    = bus.cbus_addr[gnt_idx*AW +: AW];
            bus.mem_wr_data = bus.cbus_wrdata[gnt_idx*DW +: DW];
            bus.mem_wr_en   = ~bus.cbus_cmd[gnt_idx];
            bus.mem_wr_mask = '1;
            bus.mem_en      = 1'b1;
            if (bus.cbus_cmd[gnt_idx]) begin
                bus.cbus_rresp   = NCH'(1) << gnt_idx;
            end else begin
                bus.cbus_waccept = NCH'(1) << gnt_idx;
            end
            rr_ptr_d = (gnt_idx == PW'(NCH - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    // Read tag pipeline: one stage per cycle of memory latency.
    always_comb begin
        tag_vld_d    = '0;
        tag_ch_d     = '0;
        tag_vld_d[0] = cbus_gnt & bus.cbus_cmd[gnt_idx];
        tag_ch_d[0]  = gnt_idx;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_ch_d[i]  = tag_ch_q[i-1];
        end
        bus.cbus_rvalid = tag_vld_q[RD_LAT-1] ? (NCH'(1) << tag_ch_q[RD_LAT-1]) : '0;
        bus.cbus_rdata  = bus.mem_rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            tag_vld_q <= '0;
            tag_ch_q  <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            tag_vld_q <= tag_vld_d;
            tag_ch_q  <= tag_ch_d;
        end
    end

endmodule
